i2c_target_regs: RTL

- I2C target (responder) that answers write/read transactions from the on-board I2C controller or an external host.
- Protocol: 7-bit device address, one 8-bit register-address byte, then data bytes with register-address auto-increment.
- Exposes a simple single-cycle register-bus strobe interface to a fabric-side register bank (status/ID/config).
- Open-drain style SDA drive: sda_out=0 pulls low, 1 releases. Never drives SCL (no clock stretching).

---
 rtl/i2c_target_regs.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_regs.sv
// I2C target: 7-bit address, 8-bit register pointer with auto-increment, single-cycle register-bus strobes.
// Build option: define I2C_TGT_GLITCH_FILT_EN to add a 3-sample majority filter on scl/sda.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda,
    output logic       sda_out,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic       nack_seen
);
    typedef enum logic [3:0] {IDLE, ADDR, ACK_A, REG, ACK_R, WR, ACK_W, RD, RACK, WAIT} state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_p0, sda_p0, scl_p1, sda_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

`ifdef I2C_TGT_GLITCH_FILT_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_filt <= maj3({scl_hist, scl_sync[SYNC_STAGES-1]});
            sda_filt <= maj3({sda_hist, sda_sync[SYNC_STAGES-1]});
        end
    end

    assign scl_p0 = scl_filt;
    assign sda_p0 = sda_filt;
`else
    assign scl_p0 = scl_sync[SYNC_STAGES-1];
    assign sda_p0 = sda_sync[SYNC_STAGES-1];
`endif

    // Edge detector stage: one flop of history on the conditioned bus lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p1 <= 1'b1;
            sda_p1 <= 1'b1;
        end else begin
            scl_p1 <= scl_p0;
            sda_p1 <= sda_p0;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_p0 & ~scl_p1;
    assign scl_fall  = ~scl_p0 & scl_p1;
    assign start_det = scl_p0 & scl_p1 & sda_p1 & ~sda_p0;
    assign stop_det  = scl_p0 & scl_p1 & ~sda_p1 & sda_p0;

    state_t     state;
    logic [7:0] shreg;
    logic [3:0] bit_cnt;
    logic       ack_drv, load_pend, rw;
    logic [7:0] rx_byte;
    logic       last_bit, ack_end;

    assign rx_byte  = {shreg[6:0], sda_p0};
    assign last_bit = (bit_cnt == 4'd7);
    assign ack_end  = scl_fall & ack_drv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sda_out     <= 1'b1;
            reg_addr    <= 8'h00;
            reg_wr_data <= 8'h00;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            busy        <= 1'b0;
            nack_seen   <= 1'b0;
            shreg       <= 8'h00;
            bit_cnt     <= 4'd0;
            ack_drv     <= 1'b0;
            load_pend   <= 1'b0;
            rw          <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            nack_seen <= 1'b0;
            // Bank answers the read strobe one clk later; capture it then
            load_pend <= reg_re;
            if (load_pend)
                shreg <= reg_rd_data;

            if (stop_det) begin
                state   <= IDLE;
                sda_out <= 1'b1;
                busy    <= 1'b0;
                ack_drv <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                sda_out <= 1'b1;
                bit_cnt <= 4'd0;
                ack_drv <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            bit_cnt <= 4'd0;
                            ack_drv <= 1'b0;
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state <= ACK_A;
                                busy  <= 1'b1;
                                rw    <= rx_byte[0];
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    ACK_A: begin
                        if (scl_fall && !ack_drv) begin
                            sda_out <= 1'b0;
                            ack_drv <= 1'b1;
                        end else if (ack_drv && rw && scl_rise) begin
                            // ACK low is held until RD drives the first data bit on the next fall
                            reg_re  <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= RD;
                        end else if (ack_end && !rw) begin
                            sda_out <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= REG;
                        end
                    end
                    REG: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            reg_addr <= rx_byte;
                            bit_cnt  <= 4'd0;
                            ack_drv  <= 1'b0;
                            state    <= ACK_R;
                        end
                    end
                    ACK_R: begin
                        if (scl_fall && !ack_drv) begin
                            sda_out <= 1'b0;
                            ack_drv <= 1'b1;
                        end else if (ack_end) begin
                            sda_out <= 1'b1;
                            bit_cnt <= 4'd0;
                            state   <= WR;
                        end
                    end
                    WR: if (scl_rise) begin
                        shreg   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit) begin
                            reg_wr_data <= rx_byte;
                            reg_we      <= 1'b1;
                            bit_cnt     <= 4'd0;
                            ack_drv     <= 1'b0;
                            state       <= ACK_W;
                        end
                    end
                    ACK_W: begin
                        if (scl_fall && !ack_drv) begin
                            sda_out <= 1'b0;
                            ack_drv <= 1'b1;
                        end else if (ack_end) begin
                            sda_out  <= 1'b1;
                            reg_addr <= reg_addr + 8'd1;
                            bit_cnt  <= 4'd0;
                            state    <= WR;
                        end
                    end
                    RD: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_out <= 1'b1;
                            state   <= RACK;
                        end else begin
                            sda_out <= shreg[7];
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RACK: if (scl_rise) begin
                        if (!sda_p0) begin
                            reg_addr <= reg_addr + 8'd1;
                            reg_re   <= 1'b1;
                            bit_cnt  <= 4'd0;
                            state    <= RD;
                        end else begin
                            nack_seen <= 1'b1;
                            state     <= WAIT;
                        end
                    end
                    IDLE, WAIT: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
